// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: pointer, Gray export, read-pointer
// synchronizer, full/almost-full/level flags and sticky overflow.
module afifo_wr_ctrl #(
  parameter int DW          = 64,
  parameter int AW          = 15,
  parameter int PW          = AW + 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          wclk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  input  logic [PW-1:0] rd_gray_ptr,
  input  logic [PW-1:0] af_level,
  input  logic          clr_ovf,
  output logic          wen,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] wr_addr,
  output logic [PW-1:0] wr_gray_ptr,
  output logic          full,
  output logic          alFull,
  output logic [PW-1:0] level,
  output logic          ovf
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] next_wr_ptr;
  logic [PW-1:0] next_level;
  logic [PW-1:0] rd_ptr_s;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic          accept;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // NOTE: flags are computed from next_wr_ptr, not wr_ptr, so a push accepted this
  // cycle is already counted when full is evaluated next cycle; no overrun window.
  always_comb begin
    accept      = push && !full;
    next_wr_ptr = wr_ptr + {{(PW-1){1'b0}}, accept};
    next_level  = next_wr_ptr - rd_ptr_s;
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rd_ptr_s <= '0;
    end else begin
      sync_q[0] <= rd_gray_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      rd_ptr_s <= gray2bin(sync_q[SYNC_STAGES-1]);
    end
  end

  // NOTE: non-blocking assignments throughout, so every flag samples the pre-edge state.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      wen         <= 1'b0;
      wr_data     <= '0;
      wr_addr     <= '0;
      wr_gray_ptr <= '0;
      full        <= 1'b0;
      alFull      <= 1'b0;
      level       <= '0;
      ovf         <= 1'b0;
    end else begin
      wen <= accept;
      if (accept) begin
        wr_data <= data_in;
        wr_addr <= wr_ptr[AW-1:0];
      end
      wr_ptr      <= next_wr_ptr;
      wr_gray_ptr <= next_wr_ptr ^ (next_wr_ptr >> 1);
      full        <= (next_wr_ptr[PW-1] != rd_ptr_s[PW-1]) &&
                     (next_wr_ptr[PW-2:0] == rd_ptr_s[PW-2:0]);
      level       <= next_level;
      alFull      <= (next_level >= af_level);
      // A dropped push outranks a simultaneous clear.
      if (push && full) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Bench for afifo_wr_ctrl (AW=2): directed steps plus random traffic, checked against
// an occupancy-counting reference model with a delayed view of the read pointer.
module tb_afifo_wr_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int PW    = 3;
  localparam int SS    = 2;
  localparam int DEPTH = 4;
  localparam int PMOD  = 8;

  logic          wclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [PW-1:0] rd_gray_ptr = '0;
  logic [PW-1:0] af_level = 3'd3;
  logic          wen;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_gray_ptr;
  logic          full;
  logic          alFull;
  logic [PW-1:0] level;
  logic          ovf;

  afifo_wr_ctrl #(.DW(DW), .AW(AW), .PW(PW), .SYNC_STAGES(SS)) dut (
    .wclk(wclk), .rst_n(rst_n), .push(push), .data_in(data_in),
    .rd_gray_ptr(rd_gray_ptr), .af_level(af_level), .clr_ovf(clr_ovf),
    .wen(wen), .wr_data(wr_data), .wr_addr(wr_addr), .wr_gray_ptr(wr_gray_ptr),
    .full(full), .alFull(alFull), .level(level), .ovf(ovf)
  );

  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: count of accepted writes and the read position seen SS+2 edges late.
  int m_wcnt;
  int rd_bin;
  int rd_hist[$];
  int e_wen, e_data, e_addr, e_gray, e_full, e_alfull, e_level, e_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string t);
    check({t, ".wen"},    32'(wen),         32'(e_wen));
    check({t, ".data"},   32'(wr_data),     32'(e_data));
    check({t, ".addr"},   32'(wr_addr),     32'(e_addr));
    check({t, ".gray"},   32'(wr_gray_ptr), 32'(e_gray));
    check({t, ".full"},   32'(full),        32'(e_full));
    check({t, ".alfull"}, 32'(alFull),      32'(e_alfull));
    check({t, ".level"},  32'(level),       32'(e_level));
    check({t, ".ovf"},    32'(ovf),         32'(e_ovf));
  endtask

  task automatic model_reset();
    m_wcnt = 0; rd_bin = 0; rd_hist.delete();
    e_wen = 0; e_data = 0; e_addr = 0; e_gray = 0;
    e_full = 0; e_alfull = 0; e_level = 0; e_ovf = 0;
    rd_gray_ptr = '0;
  endtask

  // One clock: drive inputs, advance the model, then sample 1 time unit after the edge.
  task automatic step(input bit p, input bit clr, input string t);
    int seen;
    bit acc;
    push        = p;
    clr_ovf     = clr;
    data_in     = DW'($urandom_range(0, 255));
    rd_gray_ptr = PW'(rd_bin ^ (rd_bin >> 1));
    acc = p && (e_full == 0);
    e_wen = acc;
    if (acc) begin
      e_data = int'(data_in);
      e_addr = m_wcnt % DEPTH;
      m_wcnt = (m_wcnt + 1) % PMOD;
    end
    rd_hist.push_back(rd_bin);
    seen     = (rd_hist.size() >= SS + 2) ? rd_hist[rd_hist.size() - (SS + 2)] : 0;
    e_level  = (m_wcnt - seen + PMOD) % PMOD;
    e_full   = (e_level == DEPTH);
    e_alfull = (e_level >= int'(af_level));
    e_gray   = m_wcnt ^ (m_wcnt >> 1);
    if (p && !acc) e_ovf = 1;
    else if (clr)  e_ovf = 0;
    @(posedge wclk);
    #1;
    check_all(t);
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset_async");
    repeat (2) @(posedge wclk);
    #1;
    check_all("reset_held");
    rst_n = 1'b1;
    step(0, 0, "idle_after_reset");

    for (int i = 0; i < 4; i++) step(1, 0, "fill");
    check("fill.full_now", 32'(full), 32'd1);
    check("fill.gray_now", 32'(wr_gray_ptr), 32'd6);

    step(1, 0, "push_full");
    step(0, 0, "ovf_sticky");
    step(1, 1, "ovf_set_wins");
    step(0, 1, "ovf_clear");
    step(0, 0, "ovf_cleared");

    rd_bin = 2;
    for (int i = 0; i < 4; i++) step(0, 0, "rd_latency");
    check("rd_latency.level", 32'(level), 32'd2);

    for (int i = 0; i < 6; i++) begin
      if (rd_bin != m_wcnt) rd_bin = (rd_bin + 1) % PMOD;
      step(1, 0, "wrap");
    end

    for (int i = 0; i < 120; i++) begin
      if ((i % 16) == 0) af_level = PW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1 && rd_bin != m_wcnt) rd_bin = (rd_bin + 1) % PMOD;
      step($urandom_range(0, 99) < 70, $urandom_range(0, 9) == 0, "random");
    end

    af_level = 3'd3;
    step(1, 0, "burst");
    step(1, 0, "burst");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midburst_reset");
    @(posedge wclk);
    #1;
    check_all("midburst_held");
    rst_n = 1'b1;
    step(1, 0, "post_reset_push");
    check("post_reset.addr0", 32'(wr_addr), 32'd0);
    for (int i = 0; i < 5; i++) step(1, 0, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/afifo_wr_ctrl.md
AFIFO_WR_CTRL -- requirements
Module: afifo_wr_ctrl

Interface
REQ-001 SHALL have parameter DW, default 64, write data width in bits.
REQ-002 SHALL have parameter AW, default 15, address width; depth MAX_DEPTH = 2**AW; legal 1..20.
REQ-003 SHALL have parameter PW, default AW+1, pointer width; other values illegal.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, read-pointer synchronizer depth; legal 2..4.
REQ-005 SHALL have port wclk, input, 1, write clock; the only clock.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-007 SHALL have port push, input, 1, write request.
REQ-008 SHALL have port data_in, input, DW, write data.
REQ-009 SHALL have port rd_gray_ptr, input, PW, read pointer, Gray-coded, asynchronous to wclk.
REQ-010 SHALL have port af_level, input, PW, programmable almost-full level, quasi-static.
REQ-011 SHALL have port clr_ovf, input, 1, clears sticky overflow flag.
REQ-012 SHALL have port wen, output, 1, memory write enable.
REQ-013 SHALL have port wr_data, output, DW, memory write data.
REQ-014 SHALL have port wr_addr, output, AW, memory write address.
REQ-015 SHALL have port wr_gray_ptr, output, PW, Gray-coded write pointer to the read domain.
REQ-016 SHALL have port full, output, 1, FIFO full.
REQ-017 SHALL have port alFull, output, 1, almost full.
REQ-018 SHALL have port level, output, PW, write-side occupancy, 0..MAX_DEPTH.
REQ-019 SHALL have port ovf, output, 1, sticky overflow flag.

Function
REQ-020 Push SHALL be accepted iff push && !full in that cycle; accepted push increments internal binary wr_ptr (PW bits, modulo 2**PW).
REQ-021 wen, wr_data, wr_addr SHALL be registered: cycle after acceptance, wen=1, wr_data=data_in, wr_addr=wr_ptr[AW-1:0] at acceptance; otherwise wen=0, and wr_data/wr_addr hold their previous values.
REQ-022 wr_gray_ptr SHALL be registered as gray(next_wr_ptr), so it always equals gray(wr_ptr); only one bit changes per increment.
REQ-023 rd_gray_ptr SHALL pass through SYNC_STAGES flops; the last stage SHALL be Gray-to-binary converted and registered as rd_ptr_s.
REQ-024 full SHALL register: next_wr_ptr[PW-1] != rd_ptr_s[PW-1] and next_wr_ptr[PW-2:0] == rd_ptr_s[PW-2:0].
REQ-025 level SHALL register (next_wr_ptr - rd_ptr_s) modulo 2**PW; pointer wrap from 2**PW-1 to 0 SHALL give correct level.
REQ-026 alFull SHALL register (next level >= af_level); af_level=0 forces alFull=1; af_level > MAX_DEPTH forces alFull=0.
REQ-027 full, level, alFull SHALL reflect an accepted push in the next cycle (no stale-pointer overrun).
REQ-028 A read-pointer change at rd_gray_ptr SHALL reach full/level/alFull exactly SYNC_STAGES+2 wclk edges later.
REQ-029 push while full SHALL be dropped (no wen, wr_ptr unchanged) and SHALL set ovf next cycle.
REQ-030 ovf SHALL clear the cycle after clr_ovf=1; simultaneous dropped push and clr_ovf SHALL leave ovf=1 (set wins).

Reset
REQ-031 rst_n low SHALL immediately clear wr_ptr, all sync flops, rd_ptr_s, wen, wr_data, wr_addr, wr_gray_ptr, full, alFull (then recomputed only after release), level, ovf to 0.
REQ-032 Reset mid-burst SHALL abort the burst; first push after release SHALL write wr_addr 0.

Verification (AW=2, PW=3, SYNC_STAGES=2, af_level=3)
REQ-033 Reset release with push=0 -> all outputs 0, including alFull=0 and level=0.
REQ-034 Push 4 consecutive cycles, rd_gray_ptr=0 -> wen on 4 cycles, wr_addr 0,1,2,3; wr_gray_ptr 1,3,2,6; level 1..4; alFull from level 3; full the cycle after the 4th acceptance.
REQ-035 Push while full, then clr_ovf -> no wen, wr_gray_ptr stays 6, ovf=1 until the cycle after clr_ovf.
REQ-036 From full, drive rd_gray_ptr=3 (binary 2) -> full=0, level=2, alFull=0 exactly 4 cycles later.
REQ-037 Wrap: 6 more pushes with read draining -> wr_ptr 7->0, level stays consistent with wr_ptr - rd_ptr modulo 8.
REQ-038 Assert rst_n low mid-burst, no clock edge -> outputs 0 immediately; next accepted push uses wr_addr 0.
